// File: rtl/motor_input_cond_if.sv
// Raw switch inputs and conditioned outputs of motor_input_cond.
// The master side drives the raw inputs and the slave (conditioner) drives the outputs.
interface motor_input_cond_if;
    logic btn_raw;
    logic up_limit_raw;
    logic dn_limit_raw;
    logic activate;
    logic up_limit;
    logic dn_limit;
    logic fault;

    modport master (
        output btn_raw, up_limit_raw, dn_limit_raw,
        input  activate, up_limit, dn_limit, fault
    );

    modport slave (
        input  btn_raw, up_limit_raw, dn_limit_raw,
        output activate, up_limit, dn_limit, fault
    );
endinterface

// File: rtl/motor_input_cond.sv
// Sync + debounce of button/limit switches; button press -> one activate pulse. MOTOR_COND_FAULT_EN adds sticky limit-conflict fault.
// Latency raw->output 2+DB_CYCLES edges; no backpressure (level inputs sampled every cycle).
module motor_input_cond #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    motor_input_cond_if.slave io
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam int BTN = 0;
    localparam int UP  = 1;
    localparam int DN  = 2;

    logic [2:0]            raw;
    logic [2:0]            sync1;
    logic [2:0]            sync2;
    logic [2:0]            d;
    logic [2:0]            d_nxt;
    logic [2:0]            load;
    logic [2:0][CNT_W-1:0] cnt;
    logic                  fault_q;
    logic                  fault_nxt;
    logic                  act_q;
    logic                  up_q;
    logic                  dn_q;

    assign raw = {io.dn_limit_raw, io.up_limit_raw, io.btn_raw};

    // A channel flips on the DB_CYCLES-th consecutive cycle that sync2 disagrees with d.
    always_comb begin
        load  = '0;
        d_nxt = d;
        for (int i = 0; i < 3; i++) begin
            load[i] = (sync2[i] != d[i]) && (cnt[i] == CNT_MAX);
            if (load[i]) begin
                d_nxt[i] = sync2[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            d     <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            d     <= d_nxt;
            for (int i = 0; i < 3; i++) begin
                if ((sync2[i] == d[i]) || load[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef MOTOR_COND_FAULT_EN
    // Both limits asserted is physically impossible; latch it until reset.
    assign fault_nxt = fault_q | (d[UP] & d[DN]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_nxt;
        end
    end
`else
    assign fault_nxt = 1'b0;
    assign fault_q   = 1'b0;
`endif

    // Outputs are registered alongside d so they change in the same cycle as d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b0;
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
        end else begin
            act_q <= d_nxt[BTN] & ~d[BTN] & ~fault_nxt;
            up_q  <= d_nxt[UP] | fault_nxt;
            dn_q  <= d_nxt[DN] | fault_nxt;
        end
    end

    assign io.activate = act_q;
    assign io.up_limit = up_q;
    assign io.dn_limit = dn_q;
    assign io.fault    = fault_q;
endmodule

// File: tb/tb_motor_input_cond.sv
// Bench for motor_input_cond (DB_CYCLES=4): directed sequences, a segment table and random traffic vs a window-based model.
// Honours MOTOR_COND_FAULT_EN the same way as the design.
module tb_motor_input_cond;
    localparam int DB = 4;
`ifdef MOTOR_COND_FAULT_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    motor_input_cond_if bus();

    motor_input_cond #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: each channel flips when the last DB synchronized samples all differ from its level.
    bit m_d[3];
    bit m_fault, m_act, m_up, m_dn;
    bit rawq[3][$];
    bit sq[3][$];

    typedef struct {
        logic btn;
        logic up;
        logic dn;
        int   hold;
        int   pulses;
        logic exp_up;
        logic exp_dn;
    } vec_t;

    vec_t tbl[12];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            m_d[ch] = 1'b0;
            rawq[ch].delete();
            sq[ch].delete();
        end
        m_fault = 1'b0;
        m_act   = 1'b0;
        m_up    = 1'b0;
        m_dn    = 1'b0;
    endtask

    task automatic model_edge();
        bit r[3];
        bit old_btn, both, fault_n, s, all_diff;
        r[0]    = bus.btn_raw;
        r[1]    = bus.up_limit_raw;
        r[2]    = bus.dn_limit_raw;
        old_btn = m_d[0];
        both    = m_d[1] & m_d[2];
        for (int ch = 0; ch < 3; ch++) begin
            rawq[ch].push_back(r[ch]);
            if (rawq[ch].size() > 3) void'(rawq[ch].pop_front());
            // value the raw input had two edges ago, i.e. what the debouncer sees now
            s = (rawq[ch].size() == 3) ? rawq[ch][0] : 1'b0;
            sq[ch].push_back(s);
            if (sq[ch].size() > DB) void'(sq[ch].pop_front());
            all_diff = (sq[ch].size() == DB);
            for (int j = 0; j < sq[ch].size(); j++) begin
                if (sq[ch][j] == m_d[ch]) all_diff = 1'b0;
            end
            if (all_diff) m_d[ch] = ~m_d[ch];
        end
        fault_n = m_fault | (FEN & both);
        m_fault = fault_n;
        m_act   = m_d[0] & ~old_btn & ~fault_n;
        m_up    = m_d[1] | fault_n;
        m_dn    = m_d[2] | fault_n;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        chk1("model_activate", bus.activate, m_act);
        chk1("model_up_limit", bus.up_limit, m_up);
        chk1("model_dn_limit", bus.dn_limit, m_dn);
        chk1("model_fault",    bus.fault,    m_fault);
    endtask

    task automatic set_in(input logic b, input logic u, input logic d);
        bus.btn_raw      = b;
        bus.up_limit_raw = u;
        bus.dn_limit_raw = d;
    endtask

    task automatic reset_clean();
        set_in(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        int pulses;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8, 0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8, 1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8, 0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 3, 0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8, 0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8, 1, 1'b0, 1'b0};

        // Reset with all raws high, then release: nothing rises before edge 5.
        set_in(1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        chk1("rst_activate", bus.activate, 1'b0);
        chk1("rst_up_limit", bus.up_limit, 1'b0);
        chk1("rst_dn_limit", bus.dn_limit, 1'b0);
        chk1("rst_fault",    bus.fault,    1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1("rel_up_limit", bus.up_limit, i >= 5);
            chk1("rel_dn_limit", bus.dn_limit, i >= 5);
            chk1("rel_activate", bus.activate, i == 5);
            chk1("rel_fault",    bus.fault,    FEN && (i >= 6));
        end

        // Held press: one pulse after edge 5, none on release.
        reset_clean();
        chk1("clean_fault", bus.fault, 1'b0);
        set_in(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("press_activate", bus.activate, i == 5);
        end
        set_in(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("release_activate", bus.activate, 1'b0);
        end

        // 3-cycle button glitch is rejected and the counter returns to idle.
        reset_clean();
        set_in(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        set_in(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1("glitch_activate", bus.activate, 1'b0);
        end
        chk1("glitch_cnt_zero", dut.cnt[0] == 3'd0, 1'b1);

        // 2-cycle low glitch on a settled upper limit.
        reset_clean();
        set_in(1'b0, 1'b1, 1'b0);
        repeat (8) tick();
        chk1("upglitch_settled", bus.up_limit, 1'b1);
        set_in(1'b0, 1'b0, 1'b0);
        repeat (2) begin
            tick();
            chk1("upglitch_low", bus.up_limit, 1'b1);
        end
        set_in(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("upglitch_after", bus.up_limit, 1'b1);
        end

        // Limit conflict followed by a press 10 cycles later.
        reset_clean();
        set_in(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 25; i++) begin
            if (i == 10) set_in(1'b1, 1'b1, 1'b1);
            tick();
            chk1("conflict_fault",    bus.fault,    FEN && (i >= 6));
            chk1("conflict_up_limit", bus.up_limit, i >= 5);
            chk1("conflict_dn_limit", bus.dn_limit, i >= 5);
            chk1("conflict_activate", bus.activate, !FEN && (i == 15));
        end

        // Reset pulse in the middle of a debounce count.
        reset_clean();
        set_in(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        model_reset();
        tick();
        chk1("midrst_activate_low", bus.activate, 1'b0);
        rst_n = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk1("midrst_activate", bus.activate, j == 6);
        end

        // Segment table, each record continuing from the previous one.
        reset_clean();
        for (int r = 0; r < 12; r++) begin
            set_in(tbl[r].btn, tbl[r].up, tbl[r].dn);
            pulses = 0;
            for (int h = 0; h < tbl[r].hold; h++) begin
                tick();
                if (bus.activate) pulses++;
            end
            chkn("tbl_pulses",   pulses,       tbl[r].pulses);
            chk1("tbl_up_limit", bus.up_limit, tbl[r].exp_up);
            chk1("tbl_dn_limit", bus.dn_limit, tbl[r].exp_dn);
            chk1("tbl_fault",    bus.fault,    1'b0);
        end

        // Random toggling against the model, with periodic resets.
        for (int blk = 0; blk < 4; blk++) begin
            reset_clean();
            for (int n = 0; n < 300; n++) begin
                if ($urandom_range(0, 5) == 0) bus.btn_raw      = ~bus.btn_raw;
                if ($urandom_range(0, 5) == 0) bus.up_limit_raw = ~bus.up_limit_raw;
                if ($urandom_range(0, 5) == 0) bus.dn_limit_raw = ~bus.dn_limit_raw;
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
